// File: rtl/demap_mode_sched.sv
// Frame sequencer and QAM/QPSK mode controller ahead of the symbol demapper.
// Optional build macro DEMAP_MODE_HYST_EN: a mode switch needs two consecutive qualifying frames.
module demap_mode_sched #(
    parameter int unsigned N_SC   = 52,
    parameter int unsigned N_SYM  = 8,
    parameter int unsigned ERR_HI = 16,
    parameter int unsigned ERR_LO = 2,
    parameter int unsigned ERRW   = 16
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    output logic            ACK_O,
    input  logic [3:0]      DAT_I,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    input  logic            ACK_I,
    output logic [3:0]      DAT_O,
    output logic            QAM,
    output logic            QPSK,
    output logic            PIL_O,
    input  logic            ERR_V_I,
    input  logic            ERR_I,
    input  logic            FORCE_EN,
    input  logic            FORCE_QAM,
    output logic            FRM_DONE,
    output logic [ERRW-1:0] ERR_CNT
);

    localparam int unsigned SCW  = $clog2(N_SC);
    localparam int unsigned SYMW = (N_SYM > 1) ? $clog2(N_SYM) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, EVAL} state_t;

    state_t            r_state;
    logic [SCW-1:0]    r_sc_cnt;
    logic [SYMW-1:0]   r_sym_cnt;
    logic [ERRW-1:0]   r_frame_err;
    logic [2:0]        r_quiet;
`ifdef DEMAP_MODE_HYST_EN
    logic              r_pend;
`endif

    logic w_halt;
    logic w_pilot;
    logic w_sc_wrap;
    logic w_last_sym;
    logic w_err_hit;
    logic w_flushed;
    logic w_switch;

    assign w_halt     = STB_O & ~ACK_I;
    assign ACK_O      = CYC_I & STB_I & WE_I & ~w_halt & (r_state == RUN);
    assign WE_O       = STB_O;
    assign w_pilot    = (r_sc_cnt == SCW'(5))  | (r_sc_cnt == SCW'(19)) |
                        (r_sc_cnt == SCW'(30)) | (r_sc_cnt == SCW'(44));
    assign w_sc_wrap  = (r_sc_cnt == SCW'(N_SC - 1));
    assign w_last_sym = (r_sym_cnt == SYMW'(N_SYM - 1));
    assign w_err_hit  = ERR_V_I & ERR_I & (r_state != EVAL);
    // Demapper pipeline is considered flushed once ERR_V_I has been quiet for 4 cycles.
    assign w_flushed  = ~STB_O & (r_quiet == 3'd4);
    assign w_switch   = (QAM  & (r_frame_err > ERRW'(ERR_HI))) |
                        (QPSK & (r_frame_err < ERRW'(ERR_LO)));

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= IDLE;
            r_sc_cnt    <= '0;
            r_sym_cnt   <= '0;
            r_frame_err <= '0;
            r_quiet     <= '0;
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            DAT_O       <= '0;
            QAM         <= 1'b1;
            QPSK        <= 1'b0;
            PIL_O       <= 1'b0;
            FRM_DONE    <= 1'b0;
            ERR_CNT     <= '0;
`ifdef DEMAP_MODE_HYST_EN
            r_pend      <= 1'b0;
`endif
        end else begin
            PIL_O    <= 1'b0;
            FRM_DONE <= 1'b0;

            if (ERR_V_I)
                r_quiet <= '0;
            else if (r_quiet != 3'd4)
                r_quiet <= r_quiet + 3'd1;

            if (w_err_hit && (r_frame_err != '1))
                r_frame_err <= r_frame_err + ERRW'(1);

            // Pilots are swallowed; data beats are forwarded one cycle later.
            if (ACK_O && !w_pilot) begin
                STB_O <= 1'b1;
                DAT_O <= DAT_I;
            end else if (ACK_I) begin
                STB_O <= 1'b0;
            end
            if (ACK_O && w_pilot)
                PIL_O <= 1'b1;

`ifdef DEMAP_MODE_HYST_EN
            if (FORCE_EN)
                r_pend <= 1'b0;
`endif

            case (r_state)
                IDLE: begin
                    if (FORCE_EN) begin
                        QAM  <= FORCE_QAM;
                        QPSK <= ~FORCE_QAM;
                    end
                    if (CYC_I) begin
                        r_state   <= RUN;
                        CYC_O     <= 1'b1;
                        r_sc_cnt  <= '0;
                        r_sym_cnt <= '0;
                    end
                end
                RUN: begin
                    if (ACK_O) begin
                        if (w_sc_wrap) begin
                            r_sc_cnt  <= '0;
                            r_sym_cnt <= r_sym_cnt + SYMW'(1);
                            if (w_last_sym)
                                r_state <= DRAIN;
                        end else begin
                            r_sc_cnt <= r_sc_cnt + SCW'(1);
                        end
                    end else if (!CYC_I) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_flushed) begin
                        CYC_O   <= 1'b0;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    ERR_CNT     <= r_frame_err;
                    r_frame_err <= '0;
                    FRM_DONE    <= 1'b1;
                    if (FORCE_EN) begin
                        QAM  <= FORCE_QAM;
                        QPSK <= ~FORCE_QAM;
                    end else begin
`ifdef DEMAP_MODE_HYST_EN
                        if (w_switch) begin
                            if (r_pend) begin
                                QAM    <= ~QAM;
                                QPSK   <= ~QPSK;
                                r_pend <= 1'b0;
                            end else begin
                                r_pend <= 1'b1;
                            end
                        end else begin
                            r_pend <= 1'b0;
                        end
`else
                        if (w_switch) begin
                            QAM  <= ~QAM;
                            QPSK <= ~QPSK;
                        end
`endif
                    end
                    if (CYC_I) begin
                        r_state   <= RUN;
                        CYC_O     <= 1'b1;
                        r_sc_cnt  <= '0;
                        r_sym_cnt <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demap_mode_sched.sv
// Self-checking bench for demap_mode_sched: frame table plus data scoreboard.
module tb_demap_mode_sched;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        CYC_I, STB_I, WE_I, ACK_O;
    logic [3:0]  DAT_I;
    logic        CYC_O, STB_O, WE_O, ACK_I;
    logic [3:0]  DAT_O;
    logic        QAM, QPSK, PIL_O;
    logic        ERR_V_I, ERR_I, FORCE_EN, FORCE_QAM, FRM_DONE;
    logic [15:0] ERR_CNT;

    demap_mode_sched dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O), .DAT_I(DAT_I),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I), .DAT_O(DAT_O),
        .QAM(QAM), .QPSK(QPSK), .PIL_O(PIL_O),
        .ERR_V_I(ERR_V_I), .ERR_I(ERR_I), .FORCE_EN(FORCE_EN), .FORCE_QAM(FORCE_QAM),
        .FRM_DONE(FRM_DONE), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK_I = ~CLK_I;

`ifdef DEMAP_MODE_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    typedef struct {
        int n_err;
        int abort_at;
        bit force_en;
        bit force_qam;
        bit halt;
        int exp_err;
        bit exp_qam;
    } frame_vec_t;

    frame_vec_t vecs[10];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [3:0] sb_q[$];
    int m_sc, n_beats, n_pushed, n_dn, n_pil, n_frm;
    logic prev_stall;
    logic [3:0] prev_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_pil(input int s);
        return (s == 5) || (s == 19) || (s == 30) || (s == 44);
    endfunction

    // One cycle: sample settled outputs, update scoreboard, advance to next falling edge.
    task automatic step();
        logic [3:0] exp_d;
        #1;
        if (STB_O && !ACK_I) begin
            chk("halt_ack_o", 32'(ACK_O), 32'd0);
            if (prev_stall) chk("halt_dat_stable", 32'(DAT_O), 32'(prev_dat));
            prev_stall = 1'b1;
            prev_dat   = DAT_O;
        end else begin
            prev_stall = 1'b0;
        end
        if (STB_O && ACK_I) begin
            n_dn++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                chk("sb_data", 32'(DAT_O), 32'(exp_d));
            end
        end
        if (PIL_O)    n_pil++;
        if (FRM_DONE) n_frm++;
        if (ACK_O) begin
            n_beats++;
            if (!is_pil(m_sc)) begin
                sb_q.push_back(DAT_I);
                n_pushed++;
            end
            m_sc = (m_sc == 51) ? 0 : m_sc + 1;
        end
        @(negedge CLK_I);
    endtask

    task automatic run_frame(input frame_vec_t v);
        int  target, cyc, halt_left;
        bit  done, halt_started;
        n_beats = 0; n_pushed = 0; n_dn = 0; n_pil = 0; n_frm = 0; m_sc = 0;
        target = (v.abort_at != 0) ? v.abort_at : 416;
        FORCE_EN = v.force_en; FORCE_QAM = v.force_qam;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
        cyc = 0; halt_left = 0; done = 1'b0; halt_started = 1'b0;
        while (!done && cyc < 1500) begin
            DAT_I   = 4'($urandom);
            ERR_V_I = (cyc >= 10) && (cyc < 10 + v.n_err);
            ERR_I   = ERR_V_I;
            if (n_beats >= target) begin
                CYC_I = 1'b0;
                STB_I = 1'b0;
            end
            if (v.halt && !halt_started && n_beats == 200) begin
                halt_left    = 5;
                halt_started = 1'b1;
            end
            ACK_I = (halt_left == 0);
            if (halt_left > 0) halt_left--;
            step();
            if (n_frm > 0) done = 1'b1;
            cyc++;
        end
        if (!done) chk("frm_timeout", 32'd0, 32'd1);
        CYC_I = 1'b0; STB_I = 1'b0; ACK_I = 1'b1; ERR_V_I = 1'b0; ERR_I = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("beats",     32'(n_beats), 32'(target));
        chk("frm_once",  32'(n_frm), 32'd1);
        chk("data_cnt",  32'(n_dn), 32'(n_pushed));
        chk("pil_cnt",   32'(n_pil), 32'(n_beats - n_pushed));
        chk("sb_empty",  32'(sb_q.size()), 32'd0);
        chk("cyc_o_rel", 32'(CYC_O), 32'd0);
        if (v.abort_at == 0) begin
            chk("data_384", 32'(n_dn), 32'd384);
            chk("pil_32",   32'(n_pil), 32'd32);
        end
        chk("err_cnt", 32'(ERR_CNT), 32'(v.exp_err));
        chk("qam",     32'(QAM), 32'(v.exp_qam));
        chk("qpsk",    32'(QPSK), 32'(!v.exp_qam));
    endtask

    task automatic check_reset_vals();
        chk("rst_cyc_o",    32'(CYC_O), 32'd0);
        chk("rst_stb_o",    32'(STB_O), 32'd0);
        chk("rst_we_o",     32'(WE_O), 32'd0);
        chk("rst_dat_o",    32'(DAT_O), 32'd0);
        chk("rst_qam",      32'(QAM), 32'd1);
        chk("rst_qpsk",     32'(QPSK), 32'd0);
        chk("rst_pil_o",    32'(PIL_O), 32'd0);
        chk("rst_frm_done", 32'(FRM_DONE), 32'd0);
        chk("rst_err_cnt",  32'(ERR_CNT), 32'd0);
        chk("rst_ack_o",    32'(ACK_O), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                n_err abort force fq halt exp_err exp_qam
        vecs[0] = '{0,   0,   1'b0, 1'b0, 1'b0, 0,  1'b1};
        vecs[1] = '{20,  0,   1'b0, 1'b0, 1'b1, 20, HYST};
        vecs[2] = '{20,  0,   1'b0, 1'b0, 1'b0, 20, 1'b0};
        vecs[3] = '{2,   0,   1'b0, 1'b0, 1'b0, 2,  1'b0};
        vecs[4] = '{1,   0,   1'b0, 1'b0, 1'b0, 1,  !HYST};
        vecs[5] = '{1,   100, 1'b0, 1'b0, 1'b0, 1,  1'b1};
        vecs[6] = '{0,   0,   1'b0, 1'b0, 1'b0, 0,  1'b1};
        vecs[7] = '{0,   0,   1'b1, 1'b0, 1'b0, 0,  1'b0};
        vecs[8] = '{0,   0,   1'b1, 1'b0, 1'b0, 0,  1'b0};
        vecs[9] = '{0,   0,   1'b1, 1'b0, 1'b0, 0,  1'b0};

        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b1;
        DAT_I = '0; ERR_V_I = 1'b0; ERR_I = 1'b0; FORCE_EN = 1'b0; FORCE_QAM = 1'b0;
        prev_stall = 1'b0; prev_dat = '0; m_sc = 0;
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b0;
        #1;
        check_reset_vals();
        @(negedge CLK_I);

        for (int i = 0; i < 10; i++) run_frame(vecs[i]);

        // Reset asserted in the middle of a forced-QPSK frame.
        FORCE_EN = 1'b0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1; m_sc = 0;
        for (int k = 0; k < 60; k++) begin
            DAT_I = 4'($urandom);
            step();
        end
        chk("pre_rst_qpsk", 32'(QPSK), 32'd1);
        RST_I = 1'b1;
        step();
        sb_q.delete();
        RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
        #1;
        check_reset_vals();
        @(negedge CLK_I);
        prev_stall = 1'b0;

        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
